// File: rtl/ctrl_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkt_pkg
// Description : Shared constants, state types and checksum helper for the
//               controller-link packet decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CSUM_XOR  = 8'hFF;

    typedef enum logic [0:0] {
        B_IDLE = 1'b0,
        B_READ = 1'b1
    } bus_state_t;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        CSUM = 2'd3
    } pkt_state_t;

    function automatic logic [7:0] calc_csum(input logic [7:0] p1, input logic [7:0] p2);
        return p1 ^ p2 ^ CSUM_XOR;
    endfunction

endpackage : ctrl_pkt_pkg
`default_nettype wire

// File: rtl/ctrl_pkt_decoder_byte_timer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_byte_timer
// Description : Inter-byte timeout counter; expired stays high once the
//               count reaches TIMEOUT_CYCLES until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_byte_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == c_limit);
    assign expired    = w_at_limit;

    // Holding at the limit keeps the counter from wrapping if nobody clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : ctrl_byte_timer
`default_nettype wire

// File: rtl/ctrl_pkt_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkt_decoder
// Description : Reads bytes from the serial receiver register port and frames
//               sync/P1/P2[/checksum] packets into held button registers.
//               Define CTRL_PKT_CSUM_EN for the 4-byte checksummed packet.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pkt_decoder #(
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = ctrl_pkt_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rda,
    input  logic [7:0] rx_data,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] p1_buttons,
    output logic [7:0] p2_buttons,
    output logic       pkt_valid,
    output logic [7:0] err_count
);

    import ctrl_pkt_pkg::*;

    bus_state_t r_bus_state;
    bus_state_t w_bus_next;
    logic       r_iocs;
    logic       r_iorw;
    logic [7:0] r_byte_q;
    logic       r_byte_vld;

    pkt_state_t r_pkt_state;
    pkt_state_t w_pkt_next;
    logic [7:0] r_p1_tmp;
`ifdef CTRL_PKT_CSUM_EN
    logic [7:0] r_p2_tmp;
    logic       w_load_p2;
`endif
    logic       w_load_p1;
    logic       w_commit;
    logic       w_error;
    logic       w_expired;
    logic       w_tmr_clr;
    logic       w_tmr_run;

    logic [7:0] r_p1_buttons;
    logic [7:0] r_p2_buttons;
    logic       r_pkt_valid;
    logic [7:0] r_err_count;

    assign iocs       = r_iocs;
    assign iorw       = r_iorw;
    assign ioaddr     = 2'b00;
    assign p1_buttons = r_p1_buttons;
    assign p2_buttons = r_p2_buttons;
    assign pkt_valid  = r_pkt_valid;
    assign err_count  = r_err_count;

    // Receiver bus: every read is followed by one idle cycle so the
    // receiver has time to drop rda before it is sampled again.
    always_comb begin
        w_bus_next = r_bus_state;
        case (r_bus_state)
            B_IDLE:  if (rda) w_bus_next = B_READ;
            B_READ:  w_bus_next = B_IDLE;
            default: w_bus_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_state <= B_IDLE;
            r_iocs      <= 1'b0;
            r_iorw      <= 1'b0;
            r_byte_q    <= 8'h00;
            r_byte_vld  <= 1'b0;
        end else begin
            r_bus_state <= w_bus_next;
            r_iocs      <= (w_bus_next == B_READ);
            r_iorw      <= (w_bus_next == B_READ);
            r_byte_vld  <= (r_bus_state == B_READ);
            if (r_bus_state == B_READ) begin
                r_byte_q <= rx_data;
            end
        end
    end

    assign w_tmr_clr = r_byte_vld || (r_pkt_state == HUNT);
    assign w_tmr_run = (r_pkt_state != HUNT);

    ctrl_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmr_clr),
        .run     (w_tmr_run),
        .expired (w_expired)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        w_pkt_next = r_pkt_state;
        w_load_p1  = 1'b0;
`ifdef CTRL_PKT_CSUM_EN
        w_load_p2  = 1'b0;
`endif
        w_commit   = 1'b0;
        w_error    = 1'b0;
        if (r_byte_vld) begin
            case (r_pkt_state)
                HUNT: begin
                    if (r_byte_q == SYNC_BYTE) w_pkt_next = P1;
                end
                P1: begin
                    w_load_p1  = 1'b1;
                    w_pkt_next = P2;
                end
                P2: begin
`ifdef CTRL_PKT_CSUM_EN
                    w_load_p2  = 1'b1;
                    w_pkt_next = CSUM;
`else
                    w_commit   = 1'b1;
                    w_pkt_next = HUNT;
`endif
                end
`ifdef CTRL_PKT_CSUM_EN
                CSUM: begin
                    if (r_byte_q == calc_csum(r_p1_tmp, r_p2_tmp)) begin
                        w_commit = 1'b1;
                    end else begin
                        w_error  = 1'b1;
                    end
                    w_pkt_next = HUNT;
                end
`endif
                default: w_pkt_next = HUNT;
            endcase
        end else if (w_expired && (r_pkt_state != HUNT)) begin
            w_error    = 1'b1;
            w_pkt_next = HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_state  <= HUNT;
            r_p1_tmp     <= 8'h00;
`ifdef CTRL_PKT_CSUM_EN
            r_p2_tmp     <= 8'h00;
`endif
            r_p1_buttons <= 8'h00;
            r_p2_buttons <= 8'h00;
            r_pkt_valid  <= 1'b0;
            r_err_count  <= 8'h00;
        end else begin
            r_pkt_state <= w_pkt_next;
            r_pkt_valid <= w_commit;
            if (w_load_p1) r_p1_tmp <= r_byte_q;
`ifdef CTRL_PKT_CSUM_EN
            if (w_load_p2) r_p2_tmp <= r_byte_q;
            if (w_commit) begin
                r_p1_buttons <= r_p1_tmp;
                r_p2_buttons <= r_p2_tmp;
            end
`else
            // Without a checksum the P2 byte commits straight from the capture register.
            if (w_commit) begin
                r_p1_buttons <= r_p1_tmp;
                r_p2_buttons <= r_byte_q;
            end
`endif
            if (w_error && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'h01;
            end
        end
    end

endmodule : ctrl_pkt_decoder
`default_nettype wire
